// File: rtl/mult_seq_ctrl.sv
// Sequential 32x32 unsigned shift-and-add multiplier controller (MULTU).
// Steps the shared external adder once per cycle and returns the 64-bit product on hi/lo.
module mult_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_upd;
    logic [CNT_W-1:0]   cnt;
    logic               capture;
    logic               step;
    logic               finish;

    // The adder carry-out becomes the new top bit, so the full 64-bit range is exact.
    assign prod_upd = {add_cout, add_sum, prod[WIDTH-1:1]};
    assign add_cin  = 1'b0;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        add_a     = '0;
        add_b     = '0;
        capture   = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                // abort outranks start, so a simultaneous request captures nothing
                if (start && !abort) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                add_a = prod[2*WIDTH-1:WIDTH];
                add_b = prod[0] ? mcand : '0;
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == LAST_ITER) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                mcand <= src_a;
                prod  <= {{WIDTH{1'b0}}, src_b};
                cnt   <= '0;
            end
            if (step) begin
                prod <= prod_upd;
                cnt  <= cnt + 1'b1;
            end
            // hi/lo are written only here, so an aborted run leaves the last result intact
            if (finish) begin
                hi <= prod_upd[2*WIDTH-1:WIDTH];
                lo <= prod_upd[WIDTH-1:0];
            end
        end
    end

endmodule
